// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Start/done handshake and result bus for the sequential BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      binary_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic                  neg;

    modport master (
        output start, binary_in,
        input  busy, done, bcd_out, overflow, neg
    );

    modport slave (
        input  start, binary_in,
        output busy, done, bcd_out, overflow, neg
    );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Iterative double-dabble binary-to-BCD converter, one bit per clock.
//            Define BIN_TO_BCD_SIGNED_EN for two's-complement input with sign.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int                c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [4*DIGITS-1:0]    r_scratch;
    logic                   r_ovf_s;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_ovf;

    logic [WIDTH-1:0]            w_mag;
    logic [4*DIGITS-1:0]         w_adj;
    logic [4*DIGITS+WIDTH-1:0]   w_pair_sh;

`ifdef BIN_TO_BCD_SIGNED_EN
    logic r_neg_s;
    logic r_neg;
    logic w_neg_in;

    // Negating the most negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
    assign w_neg_in = bus.binary_in[WIDTH-1];
    assign w_mag    = w_neg_in ? (WIDTH'(0) - bus.binary_in) : bus.binary_in;
    assign bus.neg  = r_neg;
`else
    assign w_mag    = bus.binary_in;
    assign bus.neg  = 1'b0;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ? (r_scratch[4*k +: 4] + 4'd3)
                                                               : r_scratch[4*k +: 4];
    end

    // The top adjusted bit is the one shifted out; losing it means the value exceeded DIGITS.
    assign w_pair_sh = {w_adj[4*DIGITS-2:0], r_shift, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_ovf_s   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
            r_neg_s   <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift   <= w_mag;
                        r_scratch <= '0;
                        r_ovf_s   <= 1'b0;
                        r_cnt     <= c_cnt_load;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
                        r_neg_s   <= w_neg_in;
`endif
                    end
                end
                S_SHIFT: begin
                    {r_scratch, r_shift} <= w_pair_sh;
                    if (w_adj[4*DIGITS-1]) begin
                        r_ovf_s <= 1'b1;
                    end
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= r_scratch;
                    r_ovf   <= r_ovf_s;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
                    r_neg   <= r_neg_s;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd_out  = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Scoreboard bench driving a 10-digit and an 8-digit converter in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int W  = 32;
    localparam int DA = 10;
    localparam int DB = 8;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic        neg;
        int          cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_start = 1'b0;
    logic [W-1:0]  r_bin   = '0;
    int            cyc   = 0;
    int            n_chk = 0;
    int            n_err = 0;
    exp_t          q_a[$];
    exp_t          q_b[$];

    bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(DA)) if_a ();
    bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(DB)) if_b ();

    assign if_a.start     = r_start;
    assign if_a.binary_in = r_bin;
    assign if_b.start     = r_start;
    assign if_b.binary_in = r_bin;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(DA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(DB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain decimal arithmetic on the magnitude.
    function automatic void model(input logic [W-1:0] v, input int nd,
                                  output logic [39:0] bcd, output logic ovf, output logic ng);
        longint unsigned mag, lim, m;
`ifdef BIN_TO_BCD_SIGNED_EN
        ng  = v[W-1];
        mag = ng ? ((64'd1 << W) - 64'(v)) : 64'(v);
`else
        ng  = 1'b0;
        mag = 64'(v);
`endif
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (mag >= lim);
        m   = mag;
        bcd = '0;
        for (int i = 0; i < nd; i++) begin
            bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic issue(input logic [W-1:0] v);
        exp_t ea, eb;
        int   t = 0;
        while ((if_a.busy || if_b.busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("issue_wait_timeout", 64'(t), 64'd0);
        r_start = 1'b1;
        r_bin   = v;
        @(negedge clk);
        r_start = 1'b0;
        r_bin   = $urandom;
        model(v, DA, ea.bcd, ea.ovf, ea.neg);
        model(v, DB, eb.bcd, eb.ovf, eb.neg);
        ea.cyc = cyc;
        eb.cyc = cyc;
        q_a.push_back(ea);
        q_b.push_back(eb);
        chk("busy_after_accept", 64'(if_a.busy), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && if_a.done) begin
            if (q_a.size() == 0) begin
                chk("A_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("A_bcd", 64'(if_a.bcd_out), 64'(e.bcd));
                chk("A_overflow", 64'(if_a.overflow), 64'(e.ovf));
                chk("A_neg", 64'(if_a.neg), 64'(e.neg));
                chk("A_latency", 64'(cyc - e.cyc), 64'(W + 1));
                chk("A_busy_at_done", 64'(if_a.busy), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.done) begin
            if (q_b.size() == 0) begin
                chk("B_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("B_bcd", 64'(if_b.bcd_out), 64'(e.bcd));
                chk("B_overflow", 64'(if_b.overflow), 64'(e.ovf));
                chk("B_neg", 64'(if_b.neg), 64'(e.neg));
                chk("B_latency", 64'(cyc - e.cyc), 64'(W + 1));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_A_busy"}, 64'(if_a.busy), 64'd0);
        chk({tag, "_A_done"}, 64'(if_a.done), 64'd0);
        chk({tag, "_A_bcd"}, 64'(if_a.bcd_out), 64'd0);
        chk({tag, "_A_ovf"}, 64'(if_a.overflow), 64'd0);
        chk({tag, "_A_neg"}, 64'(if_a.neg), 64'd0);
        chk({tag, "_B_bcd"}, 64'(if_b.bcd_out), 64'd0);
        chk({tag, "_B_ovf"}, 64'(if_b.overflow), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd0);
        issue(32'hFFFF_FFFF);
        issue(32'd123456789);
        issue(32'd99);
        issue(32'h8000_0000);
        issue(32'h7FFF_FFFF);
        issue(32'd1);
        for (int i = 0; i < 20; i++) issue($urandom);

        // Start pulses at 5 and 33 edges after accept must both be dropped.
        issue(32'd1234);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            r_start = (i == 4 || i == 32);
            r_bin   = 32'd5678;
            if (i == 4 || i == 32) begin
                chk("busy_during_conv", 64'(if_a.busy), 64'd1);
                chk("no_early_done", 64'(if_a.done), 64'd0);
            end
        end
        @(negedge clk);
        r_start = 1'b0;
        issue(32'd4321);

        // Asynchronous reset in the middle of a conversion.
        issue(32'd987654);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'd42);

        begin
            int t = 0;
            while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        chk("A_queue_drained", 64'(q_a.size()), 64'd0);
        chk("B_queue_drained", 64'(q_b.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock. It replaces the purely combinational divide/modulo converter feeding the seven-segment display path. This removes the wide divider chains from the critical path and adds a start/done handshake, configurable width and digit count, and overflow reporting. It sits between the register-file/ALU debug tap and the display digit drivers.

## Interface
- `WIDTH`, default 32: binary input width in bits; must be ≥ 1.
- `DIGITS`, default 10: number of BCD output digits; must be ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low.
- `start`  input  1  conversion request; sampled on rising edge.
- `binary_in`  input  WIDTH  value to convert; sampled only on the cycle `start` is accepted.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  single-cycle pulse when `bcd_out` / `overflow` / `neg` update.
- `bcd_out`  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], and digit 0 is the units digit.
- `overflow`  output  1  result did not fit in `DIGITS` digits.
- `neg`  output  1  input was negative (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `start` = 1 latches the input magnitude into the shift register.
  - It clears the BCD scratch register and the overflow scratch flag.
  - It loads the bit counter with WIDTH, then moves to SHIFT.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3.
  - The {scratch BCD, shift reg} pair is then shifted left by 1.
  - If the top digit's MSB is 1 before the shift, the sticky overflow scratch flag is set.
  - The counter decrements by 1; when it reaches 0, the FSM moves to DONE.
- DONE:
  - Copies the scratch registers to `bcd_out`, `overflow` and `neg`.
  - Asserts `done` for this cycle, then returns to IDLE.
- Result registers hold their value until the next DONE.
- Intermediate scratch values are never visible on `bcd_out`.
- On overflow, `bcd_out` = magnitude mod 10^DIGITS.
- The counter is $clog2(WIDTH+1) bits wide.
- Digit add-3 is a 4-bit add. No digit exceeds 9 after a completed shift.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd_out`=0, `overflow`=0, `neg`=0; FSM in IDLE.
- Latency: `start` accepted at edge N, giving `done`=1 in cycle N+WIDTH+1.
  - `bcd_out` is valid from that same edge.
  - Total WIDTH+2 cycles from start to IDLE.
- `busy` is high from edge N+1 through the DONE cycle inclusive.
- `start` while `busy`=1 is ignored. It is not queued, and the in-flight input is unaffected.
- `start` in the DONE cycle is ignored.
- Back-to-back throughput: one conversion per WIDTH+2 cycles.
- `rst_n` low mid-conversion: immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- `binary_in` may change freely after the accept edge.

## Configuration
- Macro: `BIN_TO_BCD_SIGNED_EN`.
- Defined:
  - `binary_in` is two's complement.
  - At accept, if MSB=1, the magnitude (−`binary_in`, as a WIDTH-bit unsigned value) is loaded and the `neg` scratch flag is set.
  - −2^(WIDTH−1) converts correctly as magnitude 2^(WIDTH−1).
  - `neg` updates at DONE.
- Undefined:
  - `binary_in` is unsigned and loaded as-is.
  - `neg` is tied to constant 0.
  - No negation logic is synthesised.

## Test plan
- Zero: WIDTH=32, DIGITS=10, `start` with 0 → `done` exactly 33 cycles after accept; `bcd_out`=0, `overflow`=0.
- Maximum unsigned: 0xFFFFFFFF (macro undefined) → digits 4,2,9,4,9,6,7,2,9,5 (MSD→LSD); `overflow`=0.
- Overflow: WIDTH=32, DIGITS=8, input 123456789 → `bcd_out` = 23456789, `overflow`=1. A following conversion of 99 → 00000099, `overflow`=0.
- Signed (macro defined): 0xFFFFFFFF → `bcd_out`=1, `neg`=1. 0x80000000 → 2147483648, `neg`=1. 0x7FFFFFFF → 2147483647, `neg`=0.
- Busy/handshake: convert 1234; pulse `start` with 5678 at cycles 5 and 33 after accept → single `done` with 1234; `busy` drops to 0; the next accepted `start` converts normally.
- Reset mid-op: assert `rst_n`=0 at cycle 10 of a conversion of 987654 → all outputs 0 immediately. After release, 42 converts to 42 with normal latency.
